// File: rtl/seq_pkg.sv
// Shared definitions for the serial bitstream feeder: FSM states,
// counter sizing helper and the default idle level of the serial line.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Level driven on seq whenever no data bit is being shifted out.
    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Bit counter width for a word of 'width' bits (never narrower than 1).
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register. The output bit is its own flop so
// the serial line is glitch-free; it falls back to IDLE_BIT whenever the
// register is neither loaded nor shifted.
module piso_shift_reg #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out
);

    logic [WIDTH-1:0] sreg_reg;
    logic [WIDTH-1:0] sreg_next;
    logic             bit_next;

    generate
        if (MSB_FIRST) begin : g_msb
            // Present bit WIDTH-1 on load, keep the remainder left-aligned.
            always_comb begin
                sreg_next = sreg_reg;
                bit_next  = IDLE_BIT;
                if (load) begin
                    bit_next  = din[WIDTH-1];
                    sreg_next = {din[WIDTH-2:0], 1'b0};
                end else if (shift) begin
                    bit_next  = sreg_reg[WIDTH-1];
                    sreg_next = {sreg_reg[WIDTH-2:0], 1'b0};
                end
            end
        end else begin : g_lsb
            // Present bit 0 on load, keep the remainder right-aligned.
            always_comb begin
                sreg_next = sreg_reg;
                bit_next  = IDLE_BIT;
                if (load) begin
                    bit_next  = din[0];
                    sreg_next = {1'b0, din[WIDTH-1:1]};
                end else if (shift) begin
                    bit_next  = sreg_reg[0];
                    sreg_next = {1'b0, sreg_reg[WIDTH-1:1]};
                end
            end
        end
    endgenerate

    // Shift register and output bit flops.
    always_ff @(posedge clk) begin
        if (srst) begin
            sreg_reg <= '0;
            bit_out  <= IDLE_BIT;
        end else begin
            sreg_reg <= sreg_next;
            bit_out  <= bit_next;
        end
    end

endmodule

// File: rtl/serial_bitstream_feeder.sv
// Serializes parallel words onto a single bit line with word-boundary flags.
// One word is shifting while a second may wait in the pending slot, so words
// stream back to back without gap cycles.
module serial_bitstream_feeder
    import seq_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             seq,
    output logic             seq_valid,
    output logic             word_start,
    output logic             word_last,
    output logic             busy
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             pend_full_reg, pend_full_next;
    logic             valid_reg, valid_next;
    logic             start_reg, start_next;
    logic             last_reg, last_next;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] load_data;
    logic             accept;

    // Only a full pending slot (or reset) blocks upstream.
    assign in_ready = !rst && !pend_full_reg;
    assign accept   = in_valid && in_ready;

    // Next-state, counter, pending slot and shifter control.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;
        valid_next     = valid_reg;
        load           = 1'b0;
        shift          = 1'b0;
        load_data      = in_data;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                    cnt_next   = '0;
                    valid_next = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST_CNT) begin
                    // Last bit on the line: chain the next word in without a gap.
                    cnt_next = '0;
                    if (pend_full_reg) begin
                        load           = 1'b1;
                        load_data      = pend_reg;
                        pend_full_next = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                    end
                end else begin
                    shift    = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (accept) begin
                        pend_next      = in_data;
                        pend_full_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
        start_next = valid_next && (cnt_next == '0);
        last_next  = valid_next && (cnt_next == LAST_CNT);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pend_reg      <= '0;
            pend_full_reg <= 1'b0;
            valid_reg     <= 1'b0;
            start_reg     <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_reg      <= pend_next;
            pend_full_reg <= pend_full_next;
            valid_reg     <= valid_next;
            start_reg     <= start_next;
            last_reg      <= last_next;
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .IDLE_BIT  (IDLE_BIT)
    ) u_piso (
        .clk     (clk),
        .srst    (rst),
        .load    (load),
        .shift   (shift),
        .din     (load_data),
        .bit_out (seq)
    );

    assign seq_valid  = valid_reg;
    assign word_start = start_reg;
    assign word_last  = last_reg;
    assign busy       = valid_reg || pend_full_reg;

endmodule

// File: tb/tb_serial_bitstream_feeder.sv
// Bench for serial_bitstream_feeder: an MSB-first and an LSB-first instance
// share the same input stream and are compared every cycle with a queue-based
// model of the words held by the block.
module tb_serial_bitstream_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;

    logic in_ready_m, seq_m, seq_valid_m, word_start_m, word_last_m, busy_m;
    logic in_ready_l, seq_l, seq_valid_l, word_start_l, word_last_l, busy_l;

    always #5 clk = ~clk;

    serial_bitstream_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready_m),
        .seq        (seq_m),
        .seq_valid  (seq_valid_m),
        .word_start (word_start_m),
        .word_last  (word_last_m),
        .busy       (busy_m)
    );

    serial_bitstream_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready_l),
        .seq        (seq_l),
        .seq_valid  (seq_valid_l),
        .word_start (word_start_l),
        .word_last  (word_last_l),
        .busy       (busy_l)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: every word the block still owns, oldest first; k = bit on the line.
    logic [W-1:0] q[$];
    int           k = 0;
    bit           chk_en = 1'b0;

    logic [W-1:0] obs_msb = '0, obs_lsb = '0, last_msb = '0, last_lsb = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    // One clock cycle: check registered outputs, drive inputs, check in_ready, advance model.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d, output logic acc);
        logic [W-1:0] w;
        logic         m_ready;
        @(negedge clk);
        if (chk_en) begin
            if (q.size() > 0) begin
                w = q[0];
                chk("seq_msb", seq_m, w[W-1-k]);
                chk("seq_lsb", seq_l, w[k]);
                chk("seq_valid", {seq_valid_m, seq_valid_l}, 2'b11);
                chk("word_start", {word_start_m, word_start_l}, {2{k == 0}});
                chk("word_last", {word_last_m, word_last_l}, {2{k == W-1}});
                chk("busy", {busy_m, busy_l}, 2'b11);
            end else begin
                chk("idle_seq", {seq_m, seq_l}, 2'b00);
                chk("idle_flags", {seq_valid_m, word_start_m, word_last_m, busy_m,
                                   seq_valid_l, word_start_l, word_last_l, busy_l}, 8'h00);
            end
            if (seq_valid_m) begin
                obs_msb = {obs_msb[W-2:0], seq_m};
                obs_lsb = {obs_lsb[W-2:0], seq_l};
                if (word_last_m) begin
                    last_msb = obs_msb;
                    last_lsb = obs_lsb;
                    $display("word out: msb-first bits=%02h lsb-first bits=%02h", obs_msb, obs_lsb);
                end
            end
        end
        rst      = r;
        in_valid = v;
        in_data  = d;
        #1;
        m_ready = !r && (q.size() < 2);
        chk("in_ready", {in_ready_m, in_ready_l}, {2{m_ready}});
        acc = v && m_ready;
        @(posedge clk);
        if (r) begin
            q.delete();
            k = 0;
        end else begin
            if (q.size() > 0) begin
                k++;
                if (k == W) begin
                    void'(q.pop_front());
                    k = 0;
                end
            end
            if (acc) q.push_back(d);
        end
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 255), acc);
    endtask

    // Hold in_valid with one word until taken; returns cycles spent.
    task automatic offer(input logic [W-1:0] d, output int n);
        logic acc;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            step(1'b0, 1'b1, d, acc);
            n++;
        end
        if (!acc) chk("offer_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic acc;
        int   n;
        // Reset and idle line.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h3C, acc);
        idle(20);

        // Single word A5: 1,0,1,0,0,1,0,1 on the MSB-first line.
        offer(8'hA5, n);
        idle(10);
        chk("a5_msb_word", last_msb, 8'hA5);

        // LSB-first 0000_0101 -> 1,0,1,0,0,0,0,0 (collected MSB-first as A0).
        offer(8'h05, n);
        idle(10);
        chk("05_lsb_word", last_lsb, 8'hA0);

        // Back-to-back FF then 00.
        offer(8'hFF, n);
        offer(8'h00, n);
        idle(20);
        chk("b2b_last_msb", last_msb, 8'h00);

        // Backpressure: third word waits for the first word to drain.
        offer(8'h81, n);
        offer(8'h42, n);
        offer(8'h3C, n);
        chk("bp_wait_cycles", n, 8);
        idle(30);
        chk("bp_last_msb", last_msb, 8'h3C);

        // Reset during bit 3 with a pending word queued; neither may resume.
        offer(8'hC3, n);
        offer(8'h99, n);
        idle(2);
        step(1'b1, 1'b0, 8'h00, acc);
        idle(12);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 255), acc);
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_bitstream_feeder.md
Name: serial_bitstream_feeder

Overview:
- Upstream stage of the 101 sequence detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `seq`.
- Consecutive words stream with no gap cycles.
- Holds one word in flight plus one pending word, so upstream sees a 2-deep buffer.
- Side-band flags mark word boundaries so downstream logic can align detections to words.

Parameters:
- WIDTH, 8, bits per input word; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- IDLE_BIT, 0, value driven on `seq` when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle; transfer happens when in_valid && in_ready at a clk edge.
- seq  output  1  serial bit stream (registered); feeds the detector's seq input.
- seq_valid  output  1  seq carries a data bit this cycle.
- word_start  output  1  seq carries the first bit of a word.
- word_last  output  1  seq carries the last bit of a word.
- busy  output  1  seq_valid || pending slot full.

Behaviour:
- Reset values, at the edge where rst=1:
  - seq=IDLE_BIT; seq_valid=0, word_start=0, word_last=0.
  - Shift register cleared, bit counter=0, pending slot empty, state=IDLE.
- in_ready:
  - Combinational: in_ready = !rst && !pending_full.
  - No word is accepted while rst=1.
  - Reset mid-word discards the shifting word and the pending word; no partial bits are output after reset.
- State machine, states IDLE and SHIFT:
  - IDLE: seq_valid=0 and seq=IDLE_BIT. An accepted word loads straight into the shifter, then go to SHIFT.
  - SHIFT: each edge advances one bit and increments the bit counter (0..WIDTH-1).
- Latency:
  - Word accepted at edge N in IDLE: its first bit appears on seq in the cycle after edge N.
  - The last bit appears WIDTH-1 cycles later.
- Registered outputs:
  - word_start=1 when counter==0.
  - word_last=1 when counter==WIDTH-1.
- Word accepted while in SHIFT: goes to the pending slot.
- Last bit showing on seq (counter==WIDTH-1), at the next edge:
  - Pending full: pending word loads into the shifter, counter=0, pending empties. No gap cycle; seq_valid stays 1.
  - Pending empty and a word is accepted at this edge: it loads straight into the shifter; same gapless behaviour.
  - Pending empty, no accept: return to IDLE; seq_valid=0, seq=IDLE_BIT.
- Simultaneous pending-to-shifter move and new accept: cannot occur, since in_ready=0 while pending is full. The slot frees one cycle later.
- Bit order:
  - MSB_FIRST=1: out bit k = word[WIDTH-1-k].
  - MSB_FIRST=0: out bit k = word[k].
- Counter width is $clog2(WIDTH). Compare against WIDTH-1 exactly; no wrap beyond it.
- in_data is sampled only on the accept edge; later changes are ignored.

Decomposition:
- Shared package `seq_pkg`:
  - state enum {IDLE, SHIFT};
  - localparam CNT_W = $clog2(WIDTH) helper function;
  - IDLE_BIT default constant.
- One sub-module, `piso_shift_reg`:
  - WIDTH-bit load/shift register with MSB_FIRST selection;
  - ports: load, shift, din, bit_out.
- Top level holds the FSM, counter, pending slot and handshake.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, in_data=8'hA5 accepted at edge N:
  - seq = 1,0,1,0,0,1,0,1 in cycles N+1..N+8;
  - word_start at N+1, word_last at N+8, seq_valid=0 at N+9;
  - downstream detector sees the 101 pattern.
- Back-to-back: in_valid held high with 8'hFF then 8'h00:
  - 16 contiguous seq_valid cycles, seq=8 ones then 8 zeros;
  - in_ready drops the cycle after the second accept;
  - word_start at cycles 1 and 9.
- Backpressure: three words offered continuously:
  - third accepted only the cycle after the first word's last bit;
  - no word lost or duplicated; output order matches input order.
- MSB_FIRST=0, in_data=8'b0000_0101:
  - seq = 1,0,1,0,0,0,0,0.
- Reset mid-word: rst=1 during bit 3 of a word with a pending word queued:
  - next cycle seq_valid=0, seq=IDLE_BIT, in_ready=1 after rst drops;
  - neither word resumes.
- Idle: in_valid=0 for 20 cycles:
  - seq=IDLE_BIT, seq_valid=0, busy=0, in_ready=1 throughout.
